// File: rtl/iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iterative_muldiv
// Purpose  : Multi-cycle UMUL/SMUL/UDIV/SDIV unit (shift-add / restoring div).
//            Optional macro MULDIV_EARLY_OUT_EN ends MUL iterations early.
// Revision : 1.0  initial release
// ============================================================================
module iterative_muldiv #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [ADDR_W-1:0] rd,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]  wb_data,
    output logic              wb_ld,
    output logic [WIDTH-1:0]  y_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic                sign_res, sign_rem, dz;
    logic [CNT_W-1:0]    cnt;
    // MUL: acc = partial product, addend = shifted multiplicand, bits = multiplier.
    // DIV: acc[WIDTH-1:0] = remainder, addend[WIDTH-1:0] = divisor, bits = quotient.
    logic [2*WIDTH-1:0]  acc, addend;
    logic [WIDTH-1:0]    bits;

    logic                a_neg, b_neg, start_dz, last_iter;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      rem_sh, diff;
    logic [2*WIDTH-1:0]  mul_res;
    logic [WIDTH-1:0]    quo_res, rem_res;

    assign a_neg    = op[0] & rs1_data[WIDTH-1];
    assign b_neg    = op[0] & rs2_data[WIDTH-1];
    assign a_mag    = a_neg ? -rs1_data : rs1_data;
    assign b_mag    = b_neg ? -rs2_data : rs2_data;
    assign start_dz = op[1] && (rs2_data == '0);

    assign rem_sh   = {acc[WIDTH-1:0], bits[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, addend[WIDTH-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) ||
                       (!op_q[1] && ((bits >> 1) == '0));
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    assign mul_res = sign_res ? -acc : acc;
    assign rem_res = sign_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_comb begin
        quo_res = sign_res ? -bits : bits;
        // Only the most-negative / -1 SDIV case yields a positive quotient with the top bit set.
        if (op_q == 2'b11 && !sign_res && bits[WIDTH-1])
            quo_res = {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = start_dz ? FIX : RUN;
            RUN:     if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            dz       <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            addend   <= '0;
            bits     <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            wb_ld    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            y_out    <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            wb_ld    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rd_q     <= rd;
                        sign_res <= a_neg ^ b_neg;
                        sign_rem <= a_neg;
                        dz       <= start_dz;
                        cnt      <= '0;
                        if (op[1]) begin
                            acc    <= '0;
                            addend <= {{WIDTH{1'b0}}, b_mag};
                            bits   <= a_mag;
                        end else begin
                            acc    <= '0;
                            addend <= {{WIDTH{1'b0}}, a_mag};
                            bits   <= b_mag;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_q[1]) begin
                        if (!diff[WIDTH]) begin
                            acc[WIDTH-1:0] <= diff[WIDTH-1:0];
                            bits           <= {bits[WIDTH-2:0], 1'b1};
                        end else begin
                            acc[WIDTH-1:0] <= rem_sh[WIDTH-1:0];
                            bits           <= {bits[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (bits[0]) acc <= acc + addend;
                        addend <= addend << 1;
                        bits   <= bits >> 1;
                    end
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        wb_rd <= rd_q;
                        wb_ld <= (rd_q != '0);
                        if (op_q[1]) begin
                            wb_data <= quo_res;
                            y_out   <= rem_res;
                        end else begin
                            wb_data <= mul_res[WIDTH-1:0];
                            y_out   <= mul_res[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_muldiv
// Purpose  : Self-checking bench for iterative_muldiv against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_iterative_muldiv;

    logic        clk = 1'b0;
    logic        reset, start, busy, done, div_zero, wb_ld;
    logic [1:0]  op;
    logic [31:0] rs1_data, rs2_data, wb_data, y_out;
    logic [4:0]  rd, wb_rd;

    int errors = 0;
    int checks = 0;

    logic [4:0]  exp_rd;
    logic [31:0] exp_wb, exp_y;

    iterative_muldiv #(.WIDTH(32), .ADDR_W(5), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
        .busy(busy), .done(done), .div_zero(div_zero),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_ld(wb_ld), .y_out(y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int hsb_plus1(input logic [31:0] v);
        int h = 0;
        for (int i = 0; i < 32; i++) if (v[i]) h = i + 1;
        return (h < 1) ? 1 : h;
    endfunction

    // Reference model: plain integer arithmetic per op
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] y, output bit dz,
                         output int lat);
        longint unsigned ua, ub, up;
        longint sa, sb, sp;
        int ia, ib;
        dz = 1'b0; q = '0; y = '0; lat = 33;
        case (o)
            2'b00: begin ua = a; ub = b; up = ua * ub; q = up[31:0]; y = up[63:32]; end
            2'b01: begin
                sa = $signed(a); sb = $signed(b); sp = sa * sb;
                q = sp[31:0]; y = sp[63:32];
            end
            2'b10: if (b == 0) dz = 1'b1; else begin q = a / b; y = a % b; end
            default: begin
                if (b == 0) dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h7FFF_FFFF; y = 32'h0;
                end else begin
                    ia = $signed(a); ib = $signed(b);
                    q = ia / ib; y = ia % ib;
                end
            end
        endcase
        if (dz) lat = 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) lat = hsb_plus1((o[0] && b[31]) ? -b : b) + 1;
`endif
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit inject, input string tag);
        logic [31:0] q, y;
        bit dz, seen;
        int lat, n;
        model(o, a, b, q, y, dz, lat);
        if (!dz) begin exp_rd = r; exp_wb = q; exp_y = y; end
        op = o; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check({tag, ".busy1"}, busy, lat > 1);
            if (inject && n == 5) begin
                start = 1'b1; op = 2'b00; rs1_data = ~a; rs2_data = b ^ 32'h5; rd = r + 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, ".timeout"}, seen, 1'b1);
        check({tag, ".latency"}, n, lat);
        check({tag, ".div_zero"}, div_zero, dz);
        check({tag, ".wb_ld"}, wb_ld, !dz && (r != 0));
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".wb_rd"}, wb_rd, exp_rd);
        check({tag, ".wb_data"}, wb_data, exp_wb);
        check({tag, ".y_out"}, y_out, exp_y);
        @(posedge clk); #1;
        check({tag, ".pulse"}, {done, div_zero, wb_ld}, 3'b000);
    endtask

    initial begin
        int cnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd = '0;
        exp_rd = '0; exp_wb = '0; exp_y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", {busy, done, div_zero, wb_ld}, 4'b0000);
        check("reset.data", {wb_rd, wb_data, y_out}, 69'd0);
        reset = 1'b0;

        do_op(2'b00, 32'd7, 32'd6, 5'd3, 1'b0, "umul7x6");
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, "umulmax");
        do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 5'd5, 1'b0, "smul");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, "sdiv");
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0, "sdivovf");
        do_op(2'b10, 32'd100, 32'd0, 5'd8, 1'b0, "udivz");
        do_op(2'b10, 32'd100, 32'd7, 5'd9, 1'b0, "udiv");
        do_op(2'b10, 32'hDEAD_BEEF, 32'd1234, 5'd10, 1'b1, "ignore");
        do_op(2'b00, 32'h1234, 32'h5678, 5'd0, 1'b0, "rd0");
        do_op(2'b11, 32'h1234_5678, 32'd0, 5'd11, 1'b0, "sdivz");

        // Abort mid-RUN with reset
        op = 2'b00; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF1; rd = 5'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd = '0; exp_wb = '0; exp_y = '0;
        check("abort.state", {busy, done, div_zero, wb_ld}, 4'b0000);
        check("abort.data", {wb_rd, wb_data, y_out}, 69'd0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || wb_ld) cnt++;
        end
        check("abort.nodone", cnt, 0);
        do_op(2'b00, 32'd7, 32'd6, 5'd3, 1'b0, "postrst");

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            do_op(ro, ra, rb, 5'($urandom_range(0, 31)), 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
